// File: rtl/top_calc.sv
// ============================================================================
//  Module   : top_calc
//  Brief    : 4-bit two-operand calculator with go/done handshake and a
//             four-state controller (IDLE, LOAD, EXEC, DONE).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module top_calc (
    input  logic       clk,
    input  logic       rst,
    input  logic       go,
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic [2:0] F,
    output logic       done,
    output logic       error,
    output logic [3:0] out_h,
    output logic [3:0] out_l
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_EXEC = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_x;
    logic [3:0] r_y;
    logic [2:0] r_f;
    logic [7:0] r_res;
    logic       r_err;
    logic [7:0] w_res;
    logic       w_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (go) w_next = S_LOAD;
            S_LOAD:  w_next = S_EXEC;
            S_EXEC:  w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x <= 4'h0;
            r_y <= 4'h0;
            r_f <= 3'h0;
        end else if (r_state == S_LOAD) begin
            r_x <= x;
            r_y <= y;
            r_f <= F;
        end
    end

    // Function unit works only on the captured operands, never the live inputs.
    always_comb begin
        w_res = 8'h00;
        w_err = 1'b0;
        case (r_f)
            3'b000: w_res = {4'h0, r_x} + {4'h0, r_y};
            3'b001: w_res = {4'h0, r_x} - {4'h0, r_y};
            3'b010: w_res = {4'h0, r_x} * {4'h0, r_y};
            3'b011: begin
                if (r_y == 4'h0) begin
                    w_err = 1'b1;
                end else begin
                    w_res = {r_x / r_y, r_x % r_y};
                end
            end
            3'b100: w_res = {4'h0, r_x & r_y};
            3'b101: w_res = {4'h0, r_x | r_y};
            3'b110: w_res = {4'h0, r_x ^ r_y};
            default: w_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_res <= 8'h00;
            r_err <= 1'b0;
        end else if (r_state == S_EXEC) begin
            r_res <= w_res;
            r_err <= w_err;
        end
    end

    assign done  = (r_state == S_DONE);
    assign error = r_err;
    assign out_h = r_res[7:4];
    assign out_l = r_res[3:0];

endmodule

`default_nettype wire

// File: tb/tb_top_calc.sv
// ============================================================================
//  Module   : tb_top_calc
//  Brief    : Directed self-checking bench for top_calc.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_top_calc;

    logic       clk;
    logic       rst;
    logic       go;
    logic [3:0] x;
    logic [3:0] y;
    logic [2:0] F;
    logic       done;
    logic       error;
    logic [3:0] out_h;
    logic [3:0] out_l;

    int n_chk = 0;
    int n_err = 0;

    top_calc u_dut (
        .clk   (clk),
        .rst   (rst),
        .go    (go),
        .x     (x),
        .y     (y),
        .F     (F),
        .done  (done),
        .error (error),
        .out_h (out_h),
        .out_l (out_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Values "a" are on the pins at the go sample, "b" at the LOAD edge.
    task automatic op(input string tag,
                      input logic [3:0] xa, input logic [3:0] ya, input logic [2:0] fa,
                      input logic [3:0] xb, input logic [3:0] yb, input logic [2:0] fb,
                      input logic [7:0] exp_r, input logic exp_e);
        x = xa; y = ya; F = fa; go = 1'b1;
        step();                                    // edge N
        go = 1'b0; x = xb; y = yb; F = fb;
        step();                                    // edge N+1
        check({tag, "_done_n1"}, done, 1'b0);
        x = ~xb; y = ~yb; F = ~fb;
        step();                                    // edge N+2
        check({tag, "_done_n2"}, done, 1'b1);
        check({tag, "_res"}, {out_h, out_l}, exp_r);
        check({tag, "_err"}, error, exp_e);
        step();                                    // edge N+3
        check({tag, "_done_n3"}, done, 1'b0);
        check({tag, "_hold"}, {error, out_h, out_l}, {exp_e, exp_r});
    endtask

    initial begin
        rst = 1'b1; go = 1'b0; x = 4'h0; y = 4'h0; F = 3'h0;
        step();
        step();
        check("rst_state", {done, error, out_h, out_l}, 10'h000);
        rst = 1'b0;
        step();

        // Sweep x=10, y=3, F changed after the go sample.
        op("add", 4'hA, 4'h3, 3'd7, 4'hA, 4'h3, 3'd0, 8'h0D, 1'b0);
        op("sub", 4'hA, 4'h3, 3'd6, 4'hA, 4'h3, 3'd1, 8'h07, 1'b0);
        op("mul", 4'hA, 4'h3, 3'd5, 4'hA, 4'h3, 3'd2, 8'h1E, 1'b0);
        op("div", 4'hA, 4'h3, 3'd4, 4'hA, 4'h3, 3'd3, 8'h31, 1'b0);
        op("and", 4'hA, 4'h3, 3'd3, 4'hA, 4'h3, 3'd4, 8'h02, 1'b0);
        op("or",  4'hA, 4'h3, 3'd2, 4'hA, 4'h3, 3'd5, 8'h0B, 1'b0);
        op("xor", 4'hA, 4'h3, 3'd1, 4'hA, 4'h3, 3'd6, 8'h09, 1'b0);
        op("rsv", 4'hA, 4'h3, 3'd0, 4'hA, 4'h3, 3'd7, 8'h00, 1'b1);

        op("div0",   4'h5, 4'h0, 3'd3, 4'h5, 4'h0, 3'd3, 8'h00, 1'b1);
        op("after0", 4'h5, 4'h2, 3'd0, 4'h5, 4'h2, 3'd0, 8'h07, 1'b0);
        op("negsub", 4'h3, 4'hA, 3'd1, 4'h3, 4'hA, 3'd1, 8'hF9, 1'b0);
        op("maxmul", 4'hF, 4'hF, 3'd2, 4'hF, 4'hF, 3'd2, 8'hE1, 1'b0);
        // x changes between go sample and LOAD: 9 + 4, not 1 + 4.
        op("latex",  4'h1, 4'h4, 3'd0, 4'h9, 4'h4, 3'd0, 8'h0D, 1'b0);

        // Asynchronous reset between edges clears outputs immediately.
        op("prerst", 4'h3, 4'hA, 3'd1, 4'h3, 4'hA, 3'd1, 8'hF9, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst", {done, error, out_h, out_l}, 10'h000);
        step();
        rst = 1'b0;
        step();

        // go held high: done on every fourth edge starting at N+2.
        x = 4'h2; y = 4'h1; F = 3'd0; go = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            check($sformatf("hold_go_%0d", i), done, (i % 4) == 2);
        end
        check("hold_go_res", {out_h, out_l}, 8'h03);
        go = 1'b0;
        step();
        step();
        step();
        check("idle_after_hold", done, 1'b0);

        // Reset while in EXEC aborts the operation.
        x = 4'h7; y = 4'h2; F = 3'd2; go = 1'b1;
        step();                                    // to LOAD
        go = 1'b0;
        step();                                    // to EXEC
        rst = 1'b1;
        #1;
        check("exec_rst_out", {done, error, out_h, out_l}, 10'h000);
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("exec_rst_nodone_%0d", i), {done, error, out_h, out_l}, 10'h000);
        end
        op("post_rst", 4'h7, 4'h2, 3'd2, 4'h7, 4'h2, 3'd2, 8'h0E, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/top_calc.md
# top_calc

Registered 4-bit two-operand calculator with a go/done handshake. A small FSM samples `go`, captures operands and the operation code, and computes one of seven arithmetic or logic functions. It presents the 8-bit result as two nibbles (`out_h`, `out_l`) with an `error` flag. It is the top-level datapath-plus-controller of the lab calculator and is driven directly by switches or a bench.

## Interface
- No parameters; all widths are fixed.
- `clk`  in  1  single system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `go`  in  1  start request; sampled only in IDLE.
- `x`  in  4  operand A, unsigned.
- `y`  in  4  operand B, unsigned.
- `F`  in  3  operation select; captured in LOAD.
- `done`  out  1  high for exactly one cycle when a new result is valid.
- `error`  out  1  error flag for the current result; held with the result.
- `out_h`  out  4  result bits [7:4].
- `out_l`  out  4  result bits [3:0].

## Operation
- FSM states: IDLE, LOAD, EXEC, DONE.
  - IDLE: waits for `go`=1, then goes to LOAD. Otherwise stays in IDLE.
  - LOAD: registers `x`, `y` and `F` unconditionally, then goes to EXEC.
  - EXEC: computes from the registered operands and writes the result and error registers, then goes to DONE.
  - DONE: `done`=1, then goes to IDLE unconditionally.
- `go` is ignored in LOAD, EXEC and DONE. If `go` is still high in IDLE after DONE, a new operation starts.
- Operands and `F` are taken at the LOAD edge, not the `go` edge. They may change after `go` is sampled.
- Result R[7:0] = {out_h, out_l}. Operands are zero-extended to 8 bits unless stated otherwise.
- Operations by `F`:
  - 000 add: R = x + y (max 30).
  - 001 subtract: R = x − y, 8-bit two's complement (3 − 10 = 0xF9).
  - 010 multiply: R = x × y (max 225 = 0xE1).
  - 011 divide: out_h = x / y, out_l = x % y. If y = 0, then error=1 and R = 0x00.
  - 100 AND: R = {4'h0, x & y}.
  - 101 OR: R = {4'h0, x | y}.
  - 110 XOR: R = {4'h0, x ^ y}.
  - 111 reserved: error=1, R = 0x00.
- `error` is 0 for every non-error case.
- Divide may use any implementation (combinational or `/`, `%`), provided it completes within EXEC.
- `out_h`, `out_l` and `error` are registered. They hold their value from the EXEC→DONE edge until the next EXEC edge or reset.

## Timing
- Reset (asynchronous, any state): state=IDLE, `done`=0, `error`=0, `out_h`=0, `out_l`=0, operand and F registers cleared.
- Reset mid-operation aborts the operation. No `done` pulse occurs for it.
- Let `go`=1 be sampled at rising edge N:
  - Edge N: IDLE→LOAD.
  - Edge N+1: operands captured, LOAD→EXEC.
  - Edge N+2: result and error registered, EXEC→DONE, `done` rises.
  - Edge N+3: DONE→IDLE, `done` falls.
- Latency is therefore 2 cycles from the `go` sample to a valid result. The minimum back-to-back period is 4 cycles.
- `done` is a Moore output: `done` = (state == DONE). There are no glitches and it is a one-cycle pulse.
- Result outputs change only on the EXEC→DONE edge. They are stable during and after the `done` pulse.

## Test plan
- Reset: assert `rst` mid-cycle without a clock edge → `done`=0, `error`=0, `out_h`=0, `out_l`=0 immediately; state=IDLE.
- Full sweep: x=1010, y=0011; for F=0..7, pulse `go` for one cycle, then set F on the next cycle. Required responses:
  - F=0: 0x0D
  - F=1: 0x07
  - F=2: 0x1E
  - F=3: out_h=3, out_l=1
  - F=4: 0x02
  - F=5: 0x0B
  - F=6: 0x09
  - F=7: 0x00 with error=1
  - All other F values: error=0.
  - In every case `done` is high exactly at edge N+2 for one cycle.
- Divide by zero: x=5, y=0, F=011 → error=1, out=0x00, `done` pulses. A following F=000 operation with y=2 → error=0, out=0x07.
- Negative subtract and maximum multiply: x=3, y=10, F=001 → 0xF9. x=15, y=15, F=010 → 0xE1.
- Handshake: hold `go`=1 continuously → a `done` pulse every 4 cycles. Changing x between the `go` sample and LOAD → the value present at LOAD is used.
- Reset in EXEC: assert `rst` one cycle after LOAD → no `done` pulse, outputs 0, then a normal operation completes after release.
